// File: rtl/frame_fifo_pkg.sv
// ============================================================================
// Module : frame_fifo_pkg
// Brief  : Shared types and default constants for the single-clock
//          frame-aware store-and-forward FIFO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package frame_fifo_pkg;

   // Write-side frame state.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IN_FRAME = 2'd1,
      DROP     = 2'd2
   } wr_state_t;

   // Default geometry and occupancy thresholds.
   localparam int c_DEF_DW         = 8;
   localparam int c_DEF_AW         = 13;
   localparam int c_DEF_AFULL_CNT  = 6660;
   localparam int c_DEF_AEMPTY_CNT = 1514;

endpackage

`default_nettype wire

// File: rtl/sdp_ram_reg.sv
// ============================================================================
// Module : sdp_ram_reg
// Brief  : Simple dual-port RAM, one write port and one read port, with
//          a registered read output.
// Rev    : 1.0  initial release
// Ports  : clk      - clock
//          arst     - asynchronous active-high reset, clears o_dout only
//          i_we     - write enable
//          i_waddr  - write address
//          i_wdata  - write data
//          i_re     - read enable, loads o_dout on the next edge
//          i_raddr  - read address
//          o_dout   - registered read data, held while i_re is low
// ============================================================================
`default_nettype none

module sdp_ram_reg #(
   parameter int WIDTH = 9,
   parameter int AW    = 13
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_re,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_dout
);

   logic [WIDTH-1:0] r_mem [0:(1<<AW)-1];
   logic [WIDTH-1:0] r_dout;

   // The array itself carries no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_dout <= '0;
      end else if (i_re) begin
         r_dout <= r_mem[i_raddr];
      end
   end

   assign o_dout = r_dout;

endmodule

`default_nettype wire

// File: rtl/frame_fifo_sc.sv
// ============================================================================
// Module : frame_fifo_sc
// Brief  : Single-clock frame-aware store-and-forward FIFO. Only whole
//          committed frames become readable; aborted frames and frames
//          that overflow are rolled back to the last commit point.
// Rev    : 1.0  initial release
// Ports  : clk           - clock
//          arst          - asynchronous active-high reset
//          i_di          - write data
//          i_we          - write strobe
//          i_eod_in      - last word of frame, qualified by i_we
//          i_abort_in    - discard the frame being written
//          i_re          - read request
//          o_do          - read data, valid one cycle after accepted read
//          o_eod_out     - frame delimiter travelling with o_do
//          o_empty       - no committed data
//          o_full        - total occupancy equals depth
//          o_afull       - total occupancy >= AFULL_CNT
//          o_aempty      - committed occupancy <= AEMPTY_CNT
//          o_frame_cnt   - committed frames not yet fully read
//          o_frame_avail - o_frame_cnt is non-zero
//          o_drop_pulse  - one-cycle pulse when an overflowing frame ends
// ============================================================================
`default_nettype none

module frame_fifo_sc
   import frame_fifo_pkg::*;
#(
   parameter int DW         = c_DEF_DW,
   parameter int AW         = c_DEF_AW,
   parameter int AFULL_CNT  = c_DEF_AFULL_CNT,
   parameter int AEMPTY_CNT = c_DEF_AEMPTY_CNT
) (
   input  logic          clk,
   input  logic          arst,
   input  logic [DW-1:0] i_di,
   input  logic          i_we,
   input  logic          i_eod_in,
   input  logic          i_abort_in,
   input  logic          i_re,
   output logic [DW-1:0] o_do,
   output logic          o_eod_out,
   output logic          o_empty,
   output logic          o_full,
   output logic          o_afull,
   output logic          o_aempty,
   output logic [AW:0]   o_frame_cnt,
   output logic          o_frame_avail,
   output logic          o_drop_pulse
);

   localparam logic [AW:0] c_ONE       = (AW+1)'(1);
   localparam logic [AW:0] c_DEPTH_OCC = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] c_AFULL_TH  = (AW+1)'(AFULL_CNT);
   localparam logic [AW:0] c_AEMPTY_TH = (AW+1)'(AEMPTY_CNT);

   // Pointers are one bit wider than the address so full and empty
   // are distinguishable by plain subtraction.
   logic [AW:0] r_wadr;
   logic [AW:0] r_wcmt;
   logic [AW:0] r_radr;
   logic [AW:0] r_fc;
   logic        r_rd_d;
   logic        r_drop;
   wr_state_t   r_state;

   wr_state_t   w_state_nxt;
   logic [AW:0] w_wadr_nxt;
   logic [AW:0] w_wcmt_nxt;
   logic        w_ram_we;
   logic        w_commit;
   logic        w_drop;

   logic [AW:0] w_total;
   logic [AW:0] w_cmt_occ;
   logic        w_full;
   logic        w_empty;
   logic        w_rd;
   logic        w_rd_eod;
   logic [DW:0] w_dout;

   assign w_total   = r_wadr - r_radr;
   assign w_cmt_occ = r_wcmt - r_radr;
   assign w_full    = (w_total == c_DEPTH_OCC);
   assign w_empty   = (w_cmt_occ == '0);
   assign w_rd      = i_re & ~w_empty;

   // ------------------------------------------------------------------
   // Write-side frame FSM
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_wadr_nxt  = r_wadr;
      w_wcmt_nxt  = r_wcmt;
      w_ram_we    = 1'b0;
      w_commit    = 1'b0;
      w_drop      = 1'b0;
      case (r_state)
         IDLE, IN_FRAME: begin
            if (i_abort_in && (r_state == IN_FRAME || i_we)) begin
               // Abort outranks any write in the same cycle, including EOD.
               w_wadr_nxt  = r_wcmt;
               w_state_nxt = IDLE;
            end else if (i_we && w_full) begin
               // Overflow: discard the partial frame; the remainder of it
               // is swallowed in DROP so the FIFO cannot deadlock.
               w_wadr_nxt = r_wcmt;
               if (i_eod_in) begin
                  w_drop      = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = DROP;
               end
            end else if (i_we) begin
               w_ram_we   = 1'b1;
               w_wadr_nxt = r_wadr + c_ONE;
               if (i_eod_in) begin
                  w_wcmt_nxt  = r_wadr + c_ONE;
                  w_commit    = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = IN_FRAME;
               end
            end
         end
         DROP: begin
            if (i_abort_in || (i_we && i_eod_in)) begin
               w_drop      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Decrement is visible in the same cycle eod_out is first presented;
   // the register catches up on the following edge.
   assign w_rd_eod = r_rd_d & w_dout[DW];

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_state <= IDLE;
         r_wadr  <= '0;
         r_wcmt  <= '0;
         r_radr  <= '0;
         r_fc    <= '0;
         r_rd_d  <= 1'b0;
         r_drop  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_wadr  <= w_wadr_nxt;
         r_wcmt  <= w_wcmt_nxt;
         r_drop  <= w_drop;
         r_rd_d  <= w_rd;
         if (w_rd) begin
            r_radr <= r_radr + c_ONE;
         end
         r_fc <= r_fc + (AW+1)'(w_commit) - (AW+1)'(w_rd_eod);
      end
   end

   sdp_ram_reg #(
      .WIDTH (DW + 1),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .arst    (arst),
      .i_we    (w_ram_we),
      .i_waddr (r_wadr[AW-1:0]),
      .i_wdata ({i_eod_in, i_di}),
      .i_re    (w_rd),
      .i_raddr (r_radr[AW-1:0]),
      .o_dout  (w_dout)
   );

   assign o_do          = w_dout[DW-1:0];
   assign o_eod_out     = w_dout[DW];
   assign o_empty       = w_empty;
   assign o_full        = w_full;
   assign o_afull       = (w_total >= c_AFULL_TH);
   assign o_aempty      = (w_cmt_occ <= c_AEMPTY_TH);
   assign o_frame_cnt   = r_fc - (AW+1)'(w_rd_eod);
   assign o_frame_avail = (o_frame_cnt != '0);
   assign o_drop_pulse  = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_frame_fifo_sc.sv
// ============================================================================
// Module : tb_frame_fifo_sc
// Brief  : Directed self-checking bench for frame_fifo_sc (AW=4, depth 16).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_frame_fifo_sc;

   localparam int DW         = 8;
   localparam int AW         = 4;
   localparam int AFULL_CNT  = 12;
   localparam int AEMPTY_CNT = 4;

   logic          clk = 1'b0;
   logic          r_arst = 1'b1;
   logic [DW-1:0] r_di = '0;
   logic          r_we = 1'b0;
   logic          r_eod = 1'b0;
   logic          r_abort = 1'b0;
   logic          r_re = 1'b0;

   logic [DW-1:0] w_do;
   logic          w_eod_out, w_empty, w_full, w_afull, w_aempty;
   logic [AW:0]   w_frame_cnt;
   logic          w_frame_avail, w_drop_pulse;

   int n_tests = 0;
   int n_fail  = 0;
   int n_drop  = 0;
   int d0;

   frame_fifo_sc #(
      .DW         (DW),
      .AW         (AW),
      .AFULL_CNT  (AFULL_CNT),
      .AEMPTY_CNT (AEMPTY_CNT)
   ) dut (
      .clk           (clk),
      .arst          (r_arst),
      .i_di          (r_di),
      .i_we          (r_we),
      .i_eod_in      (r_eod),
      .i_abort_in    (r_abort),
      .i_re          (r_re),
      .o_do          (w_do),
      .o_eod_out     (w_eod_out),
      .o_empty       (w_empty),
      .o_full        (w_full),
      .o_afull       (w_afull),
      .o_aempty      (w_aempty),
      .o_frame_cnt   (w_frame_cnt),
      .o_frame_avail (w_frame_avail),
      .o_drop_pulse  (w_drop_pulse)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (w_drop_pulse) n_drop++;
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string pfx);
      chk({pfx, "_empty"},  32'(w_empty),       32'd1);
      chk({pfx, "_aempty"}, 32'(w_aempty),      32'd1);
      chk({pfx, "_full"},   32'(w_full),        32'd0);
      chk({pfx, "_afull"},  32'(w_afull),       32'd0);
      chk({pfx, "_fcnt"},   32'(w_frame_cnt),   32'd0);
      chk({pfx, "_avail"},  32'(w_frame_avail), 32'd0);
      chk({pfx, "_do"},     32'(w_do),          32'd0);
      chk({pfx, "_eod"},    32'(w_eod_out),     32'd0);
      chk({pfx, "_drop"},   32'(w_drop_pulse),  32'd0);
   endtask

   task automatic put(input logic [7:0] d, input logic e);
      r_we  = 1'b1;
      r_di  = d;
      r_eod = e;
      cyc();
      r_we  = 1'b0;
      r_eod = 1'b0;
   endtask

   initial begin
      // Reset state
      cyc();
      cyc();
      chk_reset("rst");
      r_arst = 1'b0;

      // T1: three-byte frame, readable only after EOD
      put(8'hA1, 1'b0);
      chk("t1_empty_a", 32'(w_empty), 32'd1);
      put(8'hA2, 1'b0);
      chk("t1_empty_b", 32'(w_empty), 32'd1);
      put(8'hA3, 1'b1);
      chk("t1_empty_c", 32'(w_empty), 32'd0);
      chk("t1_fcnt",    32'(w_frame_cnt), 32'd1);
      chk("t1_avail",   32'(w_frame_avail), 32'd1);
      r_re = 1'b1;
      cyc();
      chk("t1_do0",  32'(w_do), 32'hA1);
      chk("t1_eod0", 32'(w_eod_out), 32'd0);
      cyc();
      chk("t1_do1",  32'(w_do), 32'hA2);
      chk("t1_eod1", 32'(w_eod_out), 32'd0);
      cyc();
      chk("t1_do2",  32'(w_do), 32'hA3);
      chk("t1_eod2", 32'(w_eod_out), 32'd1);
      chk("t1_fcnt0", 32'(w_frame_cnt), 32'd0);
      chk("t1_empty_d", 32'(w_empty), 32'd1);
      cyc();
      // read while empty leaves output untouched
      chk("t1_hold_do",  32'(w_do), 32'hA3);
      chk("t1_hold_eod", 32'(w_eod_out), 32'd1);
      chk("t1_hold_fc",  32'(w_frame_cnt), 32'd0);
      r_re = 1'b0;

      // T2: abort rolls back to the commit point
      put(8'hB1, 1'b0);
      put(8'hB2, 1'b0);
      r_abort = 1'b1;
      cyc();
      r_abort = 1'b0;
      chk("t2_wadr",  32'(dut.r_wadr), 32'd3);
      chk("t2_wcmt",  32'(dut.r_wcmt), 32'd3);
      chk("t2_empty", 32'(w_empty), 32'd1);
      chk("t2_fcnt",  32'(w_frame_cnt), 32'd0);
      put(8'h55, 1'b1);
      chk("t2_fcnt1", 32'(w_frame_cnt), 32'd1);
      r_re = 1'b1;
      cyc();
      r_re = 1'b0;
      chk("t2_do",   32'(w_do), 32'h55);
      chk("t2_eod",  32'(w_eod_out), 32'd1);
      chk("t2_fcnt0", 32'(w_frame_cnt), 32'd0);

      // T3: overflowing frame dropped, committed frame untouched
      for (int i = 0; i < 10; i++) put(8'(8'h10 + i), 1'(i == 9));
      chk("t3_fcnt",   32'(w_frame_cnt), 32'd1);
      chk("t3_aempty", 32'(w_aempty), 32'd0);
      chk("t3_afull",  32'(w_afull), 32'd0);
      d0 = n_drop;
      for (int i = 0; i < 20; i++) begin
         r_we  = 1'b1;
         r_di  = 8'(8'h20 + i);
         r_eod = 1'(i == 19);
         cyc();
         if (i == 5) begin
            chk("t3_full",   32'(w_full), 32'd1);
            chk("t3_afull1", 32'(w_afull), 32'd1);
         end
         if (i == 6) begin
            chk("t3_full_rb", 32'(w_full), 32'd0);
            chk("t3_wadr_rb", 32'(dut.r_wadr), 32'd14);
         end
      end
      r_we  = 1'b0;
      r_eod = 1'b0;
      chk("t3_drop_hi", 32'(w_drop_pulse), 32'd1);
      cyc();
      chk("t3_drop_lo", 32'(w_drop_pulse), 32'd0);
      chk("t3_drop_n",  32'(n_drop - d0), 32'd1);
      chk("t3_wadr",    32'(dut.r_wadr), 32'd14);
      chk("t3_wcmt",    32'(dut.r_wcmt), 32'd14);
      chk("t3_fcnt2",   32'(w_frame_cnt), 32'd1);
      r_re = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("t3_do",  32'(w_do), 32'(8'h10 + i));
         chk("t3_eod", 32'(w_eod_out), 32'(i == 9));
      end
      r_re = 1'b0;
      chk("t3_empty", 32'(w_empty), 32'd1);
      chk("t3_fcnt0", 32'(w_frame_cnt), 32'd0);

      // T4: three 5-byte frames across the address wrap
      for (int i = 0; i < 15; i++) begin
         put(8'(8'h40 + i), 1'((i % 5) == 4));
         chk("t4_w_afull", 32'(w_afull), 32'((i + 1) >= AFULL_CNT));
         chk("t4_w_fcnt",  32'(w_frame_cnt), 32'((i + 1) / 5));
         chk("t4_w_empty", 32'(w_empty), 32'((i + 1) < 5));
      end
      chk("t4_full", 32'(w_full), 32'd0);
      r_re = 1'b1;
      for (int i = 0; i < 15; i++) begin
         cyc();
         chk("t4_do",     32'(w_do), 32'(8'h40 + i));
         chk("t4_eod",    32'(w_eod_out), 32'((i % 5) == 4));
         chk("t4_fcnt",   32'(w_frame_cnt), 32'(3 - (i + 1) / 5));
         chk("t4_aempty", 32'(w_aempty), 32'((14 - i) <= AEMPTY_CNT));
         chk("t4_afull",  32'(w_afull), 32'((14 - i) >= AFULL_CNT));
      end
      r_re = 1'b0;
      chk("t4_empty", 32'(w_empty), 32'd1);

      // T5: commit and eod_out on the same edge; abort beats EOD
      put(8'h61, 1'b0);
      put(8'h62, 1'b1);
      chk("t5_fcnt_a", 32'(w_frame_cnt), 32'd1);
      r_we = 1'b1; r_di = 8'h71; r_eod = 1'b0; r_re = 1'b1;
      cyc();
      chk("t5_do0",    32'(w_do), 32'h61);
      chk("t5_fcnt_b", 32'(w_frame_cnt), 32'd1);
      r_di = 8'h72; r_eod = 1'b1;
      cyc();
      r_we = 1'b0; r_eod = 1'b0;
      chk("t5_do1",    32'(w_do), 32'h62);
      chk("t5_eod1",   32'(w_eod_out), 32'd1);
      chk("t5_fcnt_c", 32'(w_frame_cnt), 32'd1);
      cyc();
      chk("t5_do2",    32'(w_do), 32'h71);
      chk("t5_fcnt_d", 32'(w_frame_cnt), 32'd1);
      cyc();
      r_re = 1'b0;
      chk("t5_do3",    32'(w_do), 32'h72);
      chk("t5_eod3",   32'(w_eod_out), 32'd1);
      chk("t5_fcnt_e", 32'(w_frame_cnt), 32'd0);
      put(8'h81, 1'b0);
      r_we = 1'b1; r_di = 8'h82; r_eod = 1'b1; r_abort = 1'b1;
      cyc();
      r_we = 1'b0; r_eod = 1'b0; r_abort = 1'b0;
      chk("t5_ab_empty", 32'(w_empty), 32'd1);
      chk("t5_ab_fcnt",  32'(w_frame_cnt), 32'd0);
      chk("t5_ab_wadr",  32'(dut.r_wadr), 32'd1);
      chk("t5_ab_wcmt",  32'(dut.r_wcmt), 32'd1);
      cyc();
      chk("t5_ab_empty2", 32'(w_empty), 32'd1);

      // T6: asynchronous reset mid-frame and mid-read
      put(8'hC0, 1'b0);
      put(8'hC1, 1'b1);
      r_we = 1'b1; r_di = 8'h91; r_eod = 1'b0; r_re = 1'b1;
      cyc();
      chk("t6_do_pre", 32'(w_do), 32'hC0);
      r_di = 8'h92;
      @(posedge clk);
      #2 r_arst = 1'b1;
      #1 chk_reset("t6_arst");
      r_we = 1'b0; r_re = 1'b0;
      cyc();
      cyc();
      r_arst = 1'b0;
      put(8'h5A, 1'b0);
      put(8'h5B, 1'b1);
      chk("t6_fcnt",  32'(w_frame_cnt), 32'd1);
      chk("t6_empty", 32'(w_empty), 32'd0);
      r_re = 1'b1;
      cyc();
      chk("t6_do0",  32'(w_do), 32'h5A);
      chk("t6_eod0", 32'(w_eod_out), 32'd0);
      cyc();
      r_re = 1'b0;
      chk("t6_do1",   32'(w_do), 32'h5B);
      chk("t6_eod1",  32'(w_eod_out), 32'd1);
      chk("t6_fcnt0", 32'(w_frame_cnt), 32'd0);
      chk("t6_empty2", 32'(w_empty), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
